// File: rtl/acq_trigger_ctrl.sv
// Acquisition trigger sequencer: arms, waits for a level/edge match on the probe,
// then forwards a bounded number of post-trigger samples until done or overflow.
module acq_trigger_ctrl #(
    parameter int unsigned PROBE_W = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acq_enable,
    input  logic               sample_strobe,
    input  logic [PROBE_W-1:0] probe,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic [PROBE_W-1:0] trig_edge,
    input  logic [CNT_W-1:0]   sample_limit,
    input  logic               fifo_overflow,
    output logic [PROBE_W-1:0] sample_out,
    output logic               sample_valid,
    output logic [2:0]         state,
    output logic               triggered,
    output logic               stalled,
    output logic [CNT_W-1:0]   sample_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_STALLED = 3'd4
    } state_t;

    state_t             state_q;
    logic [PROBE_W-1:0] prev_q;
    logic               prev_valid_q;

    logic               level_ok;
    logic               edge_ok;
    logic               match;
    logic [CNT_W-1:0]   count_inc;
    logic               count_hit;

    // Trigger qualification; edge bits need a previous sample taken while armed.
    always_comb begin
        level_ok = ((probe ^ trig_value) & trig_mask) == '0;
        edge_ok  = (trig_edge == '0) ||
                   (prev_valid_q && (((probe ^ prev_q) & trig_edge) == trig_edge));
        match    = level_ok && edge_ok;
    end

    // Saturating next count; the count is zero while armed, so the trigger sample becomes 1.
    always_comb begin
        count_inc = (sample_count == '1) ? sample_count : sample_count + CNT_W'(1);
        count_hit = (sample_limit != '0) && (count_inc == sample_limit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            triggered    <= 1'b0;
            stalled      <= 1'b0;
            sample_count <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!acq_enable) begin
                state_q      <= ST_IDLE;
                triggered    <= 1'b0;
                stalled      <= 1'b0;
                sample_count <= '0;
                prev_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_ARMED;
                        prev_valid_q <= 1'b0;
                        sample_count <= '0;
                    end
                    ST_ARMED: begin
                        if (fifo_overflow) begin
                            state_q <= ST_STALLED;
                            stalled <= 1'b1;
                        end else if (sample_strobe) begin
                            prev_q       <= probe;
                            prev_valid_q <= 1'b1;
                            if (match) begin
                                triggered    <= 1'b1;
                                sample_out   <= probe;
                                sample_valid <= 1'b1;
                                sample_count <= count_inc;
                                state_q      <= count_hit ? ST_DONE : ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (fifo_overflow) begin
                            state_q <= ST_STALLED;
                            stalled <= 1'b1;
                        end else if (sample_strobe) begin
                            sample_out   <= probe;
                            sample_valid <= 1'b1;
                            sample_count <= count_inc;
                            if (count_hit) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE, ST_STALLED: begin
                        // Terminal until acquisition is disabled.
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Directed, table-driven bench for acq_trigger_ctrl with hand sequences for multi-cycle cases.
module tb_acq_trigger_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acq_enable = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [15:0] probe = '0;
    logic [15:0] trig_mask = '0;
    logic [15:0] trig_value = '0;
    logic [15:0] trig_edge = '0;
    logic [31:0] sample_limit = '0;
    logic        fifo_overflow = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [2:0]  state;
    logic        triggered;
    logic        stalled;
    logic [31:0] sample_count;

    int tests = 0;
    int fails = 0;

    acq_trigger_ctrl #(.PROBE_W(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .acq_enable   (acq_enable),
        .sample_strobe(sample_strobe),
        .probe        (probe),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .trig_edge    (trig_edge),
        .sample_limit (sample_limit),
        .fifo_overflow(fifo_overflow),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .state        (state),
        .triggered    (triggered),
        .stalled      (stalled),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, stb, ovf;
        logic [15:0] probe, mask, value, edg;
        logic [31:0] limit;
        logic        ev;
        logic [15:0] eo;
        logic [2:0]  es;
        logic [31:0] ec;
        logic        et, est;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, e, s, o, input logic [15:0] p, m, v, ed,
                       input logic [31:0] l, input logic ev, input logic [15:0] eo,
                       input logic [2:0] es, input logic [31:0] ec, input logic et, est);
        vec_t x;
        x.rst = r; x.en = e; x.stb = s; x.ovf = o; x.probe = p;
        x.mask = m; x.value = v; x.edg = ed; x.limit = l;
        x.ev = ev; x.eo = eo; x.es = es; x.ec = ec; x.et = et; x.est = est;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic step(input logic r, e, s, o, input logic [15:0] p);
        rst = r; acq_enable = e; sample_strobe = s; fifo_overflow = o; probe = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gaps[10];
        int nvalid;

        // Level trigger on bit0, limit 4
        add(1,0,0,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd0,32'd0,0,0);
        add(0,1,0,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h0001, 16'h0001,16'h0001,16'h0000,32'd4, 1,16'h1,3'd2,32'd1,1,0);
        add(0,1,0,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd2,32'd1,1,0);
        add(0,1,1,0,16'h0002, 16'h0001,16'h0001,16'h0000,32'd4, 1,16'h2,3'd2,32'd2,1,0);
        add(0,1,1,0,16'h0003, 16'h0001,16'h0001,16'h0000,32'd4, 1,16'h3,3'd2,32'd3,1,0);
        add(0,1,1,0,16'h0004, 16'h0001,16'h0001,16'h0000,32'd4, 1,16'h4,3'd3,32'd4,1,0);
        add(0,1,1,0,16'h0005, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd3,32'd4,1,0);
        add(0,1,0,1,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd3,32'd4,1,0);
        add(0,0,0,0,16'h0000, 16'h0001,16'h0001,16'h0000,32'd4, 0,16'h0,3'd0,32'd0,0,0);
        // Falling edge on bit7 needs a previous sample
        add(0,1,0,0,16'h0000, 16'h0000,16'h0000,16'h0080,32'd0, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h0080, 16'h0000,16'h0000,16'h0080,32'd0, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h0000, 16'h0000,16'h0000,16'h0080,32'd0, 1,16'h0,3'd2,32'd1,1,0);
        add(0,1,1,0,16'h0080, 16'h0000,16'h0000,16'h0080,32'd0, 1,16'h80,3'd2,32'd2,1,0);
        add(0,0,0,0,16'h0000, 16'h0000,16'h0000,16'h0080,32'd0, 0,16'h0,3'd0,32'd0,0,0);
        // Limit 1: trigger sample alone completes
        add(0,1,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,32'd1, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,0,16'h1234, 16'h0000,16'h0000,16'h0000,32'd1, 1,16'h1234,3'd3,32'd1,1,0);
        add(0,1,1,0,16'h5555, 16'h0000,16'h0000,16'h0000,32'd1, 0,16'h0,3'd3,32'd1,1,0);
        add(0,0,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,32'd1, 0,16'h0,3'd0,32'd0,0,0);
        // Overflow while armed drops the strobe
        add(0,1,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,32'd0, 0,16'h0,3'd1,32'd0,0,0);
        add(0,1,1,1,16'h0009, 16'h0000,16'h0000,16'h0000,32'd0, 0,16'h0,3'd4,32'd0,0,1);
        add(0,0,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,32'd0, 0,16'h0,3'd0,32'd0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            trig_mask = vecs[i].mask; trig_value = vecs[i].value;
            trig_edge = vecs[i].edg;  sample_limit = vecs[i].limit;
            step(vecs[i].rst, vecs[i].en, vecs[i].stb, vecs[i].ovf, vecs[i].probe);
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].es));
            chk($sformatf("v%0d valid", i), 32'(sample_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d count", i), sample_count, vecs[i].ec);
            chk($sformatf("v%0d triggered", i), 32'(triggered), 32'(vecs[i].et));
            chk($sformatf("v%0d stalled", i), 32'(stalled), 32'(vecs[i].est));
            if (vecs[i].ev) chk($sformatf("v%0d out", i), 32'(sample_out), 32'(vecs[i].eo));
        end

        // Unlimited run: 10 strobes, back-to-back then 5 clocks apart
        trig_mask = '0; trig_value = '0; trig_edge = '0; sample_limit = '0;
        gaps = '{1, 1, 1, 1, 1, 5, 5, 5, 5, 5};
        nvalid = 0;
        step(0, 1, 0, 0, 16'h0);
        chk("run armed", 32'(state), 32'd1);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < gaps[i] - 1; k++) begin
                step(0, 1, 0, 0, 16'h0);
                chk($sformatf("run idle%0d_%0d valid", i, k), 32'(sample_valid), 32'd0);
            end
            step(0, 1, 1, 0, 16'(16'h100 + i));
            if (sample_valid) nvalid++;
            chk($sformatf("run s%0d valid", i), 32'(sample_valid), 32'd1);
            chk($sformatf("run s%0d out", i), 32'(sample_out), 32'(16'h100 + i));
            chk($sformatf("run s%0d count", i), sample_count, 32'(i + 1));
        end
        step(0, 1, 0, 0, 16'h0);
        chk("run valids", 32'(nvalid), 32'd10);
        chk("run state", 32'(state), 32'd2);
        chk("run final count", sample_count, 32'd10);
        chk("run triggered", 32'(triggered), 32'd1);
        step(0, 0, 0, 0, 16'h0);
        chk("abort state", 32'(state), 32'd0);
        chk("abort count", sample_count, 32'd0);
        chk("abort triggered", 32'(triggered), 32'd0);

        // Overflow with a strobe in RUN
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 16'h000A);
        chk("ovf trig valid", 32'(sample_valid), 32'd1);
        step(0, 1, 1, 1, 16'h000B);
        chk("ovf state", 32'(state), 32'd4);
        chk("ovf valid", 32'(sample_valid), 32'd0);
        chk("ovf stalled", 32'(stalled), 32'd1);
        chk("ovf count", sample_count, 32'd1);
        step(0, 1, 1, 1, 16'h000C);
        chk("ovf hold state", 32'(state), 32'd4);
        chk("ovf hold valid", 32'(sample_valid), 32'd0);
        step(0, 0, 0, 1, 16'h0);
        chk("ovf clear state", 32'(state), 32'd0);
        chk("ovf clear stalled", 32'(stalled), 32'd0);
        step(0, 0, 0, 0, 16'h0);

        // Reset in the middle of a run
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0077);
        chk("rst pre valid", 32'(sample_valid), 32'd1);
        chk("rst pre state", 32'(state), 32'd2);
        step(1, 1, 0, 0, 16'h0);
        chk("rst valid", 32'(sample_valid), 32'd0);
        chk("rst state", 32'(state), 32'd0);
        chk("rst count", sample_count, 32'd0);
        chk("rst triggered", 32'(triggered), 32'd0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0003);
        chk("rst2 pre valid", 32'(sample_valid), 32'd1);
        step(1, 1, 1, 0, 16'h0004);
        chk("rst2 squash valid", 32'(sample_valid), 32'd0);
        chk("rst2 state", 32'(state), 32'd0);
        chk("rst2 out", 32'(sample_out), 32'd0);
        step(0, 0, 0, 0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
